// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// One operation takes at least 3 cycles: accept (IDLE), drive the ALU (ISSUE), return the result (RESP).
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      ReqValid,
    output logic [NREQ-1:0]      ReqReady,
    input  logic [4*NREQ-1:0]    ReqALUCtrl,
    input  logic [XLEN*NREQ-1:0] ReqA,
    input  logic [XLEN*NREQ-1:0] ReqB,
    output logic [3:0]           AluCtrl,
    output logic [XLEN-1:0]      AluA,
    output logic [XLEN-1:0]      AluB,
    input  logic [XLEN-1:0]      AluResult,
    input  logic                 AluZero,
    output logic [NREQ-1:0]      RspValid,
    input  logic [NREQ-1:0]      RspReady,
    output logic [XLEN-1:0]      RspResult,
    output logic                 RspZero,
    output logic                 Busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state, next_state;
    logic [PW-1:0] ptr, grant, winner;
    logic          found, accept, rsp_done;

    // Round-robin search starting at ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && ReqValid[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    assign accept   = (state == IDLE) && found;
    assign rsp_done = (state == RESP) && RspReady[grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = RESP;
            RESP:    if (rsp_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ReqReady = '0;
        RspValid = '0;
        Busy     = (state != IDLE);
        if (state == IDLE && found) begin
            ReqReady[winner] = 1'b1;
        end
        if (state == RESP) begin
            RspValid[grant] = 1'b1;
        end
    end

    // The accepted payload is latched straight into the ALU drive registers,
    // so the ALU sees stable register outputs throughout ISSUE and keeps them afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            ptr       <= '0;
            AluCtrl   <= 4'b0000;
            AluA      <= '0;
            AluB      <= '0;
            RspResult <= '0;
            RspZero   <= 1'b0;
        end else begin
            if (accept) begin
                grant   <= winner;
                AluCtrl <= ReqALUCtrl[4*winner +: 4];
                AluA    <= ReqA[XLEN*winner +: XLEN];
                AluB    <= ReqB[XLEN*winner +: XLEN];
            end
            if (state == ISSUE) begin
                RspResult <= AluResult;
                RspZero   <= AluZero;
            end
            if (rsp_done) begin
                ptr <= (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a cycle table for basic transactions plus
// hand-written sequences for fairness, response stall and reset mid-operation.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready;
    logic [7:0]  req_alu_ctrl;
    logic [63:0] req_a, req_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(2), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqALUCtrl(req_alu_ctrl),
        .ReqA(req_a), .ReqB(req_b),
        .AluCtrl(alu_ctrl), .AluA(alu_a), .AluB(alu_b),
        .AluResult(alu_result), .AluZero(alu_zero),
        .RspValid(rsp_valid), .RspReady(rsp_ready),
        .RspResult(rsp_result), .RspZero(rsp_zero), .Busy(busy)
    );

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        case (alu_ctrl)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    typedef struct {
        logic        rst;
        logic [1:0]  rv;
        logic [3:0]  c0;
        logic [31:0] a0, b0;
        logic [3:0]  c1;
        logic [31:0] a1, b1;
        logic [1:0]  rr;
        logic [1:0]  e_rdy, e_rspv;
        logic        e_busy;
        logic [3:0]  e_ctrl;
        logic [31:0] e_a, e_b, e_res;
        logic        e_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [1:0] rv,
                                input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic [1:0] rr, input logic [1:0] e_rdy, input logic [1:0] e_rspv,
                                input logic e_busy, input logic [3:0] e_ctrl, input logic [31:0] e_a,
                                input logic [31:0] e_b, input logic [31:0] e_res, input logic e_zero);
        vec_t v;
        v.rst = rst; v.rv = rv; v.c0 = c0; v.a0 = a0; v.b0 = b0;
        v.c1 = c1; v.a1 = a1; v.b1 = b1; v.rr = rr;
        v.e_rdy = e_rdy; v.e_rspv = e_rspv; v.e_busy = e_busy; v.e_ctrl = e_ctrl;
        v.e_a = e_a; v.e_b = e_b; v.e_res = e_res; v.e_zero = e_zero;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst_n        = ~v.rst;
        req_valid    = v.rv;
        req_alu_ctrl = {v.c1, v.c0};
        req_a        = {v.a1, v.a0};
        req_b        = {v.b1, v.b0};
        rsp_ready    = v.rr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_alu_ctrl = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        repeat (2) @(posedge clk);

        // Single add by req0, then a stall-free response.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 5, 7, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2, 5, 7, 0, 0, 0, 3, 0, 0, 1, 2, 5, 7, 0, 0));
        vecs.push_back(mk(0, 0, 2, 5, 7, 0, 0, 0, 3, 0, 1, 1, 2, 5, 7, 12, 0));
        vecs.push_back(mk(0, 0, 2, 5, 7, 0, 0, 0, 3, 0, 0, 0, 2, 5, 7, 12, 0));
        // Simultaneous requests right after reset: req0 sub wins, then req1 or.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3, 6, 9, 9, 1, 'hF0, 'h0F, 3, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2, 6, 9, 9, 1, 'hF0, 'h0F, 3, 0, 0, 1, 6, 9, 9, 0, 0));
        vecs.push_back(mk(0, 2, 6, 9, 9, 1, 'hF0, 'h0F, 3, 0, 1, 1, 6, 9, 9, 0, 1));
        vecs.push_back(mk(0, 2, 6, 9, 9, 1, 'hF0, 'h0F, 3, 2, 0, 0, 6, 9, 9, 0, 1));
        vecs.push_back(mk(0, 0, 6, 9, 9, 1, 'hF0, 'h0F, 3, 0, 0, 1, 1, 'hF0, 'h0F, 0, 1));
        vecs.push_back(mk(0, 0, 6, 9, 9, 1, 'hF0, 'h0F, 3, 0, 2, 1, 1, 'hF0, 'h0F, 'hFF, 0));
        vecs.push_back(mk(0, 0, 6, 9, 9, 1, 'hF0, 'h0F, 3, 0, 0, 0, 1, 'hF0, 'h0F, 'hFF, 0));
        // Only req1 valid with ptr=0; response held while only the non-granted RspReady bit is set.
        vecs.push_back(mk(0, 2, 0, 0, 0, 0, 'hFFFF0000, 'h00FFFF00, 1, 2, 0, 0, 1, 'hF0, 'h0F, 'hFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'hFFFF0000, 'h00FFFF00, 1, 0, 0, 1, 0, 'hFFFF0000, 'h00FFFF00, 'hFF, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'hFFFF0000, 'h00FFFF00, 1, 0, 2, 1, 0, 'hFFFF0000, 'h00FFFF00, 'h00FF0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'hFFFF0000, 'h00FFFF00, 2, 0, 2, 1, 0, 'hFFFF0000, 'h00FFFF00, 'h00FF0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'hFFFF0000, 'h00FFFF00, 0, 0, 0, 0, 0, 'hFFFF0000, 'h00FFFF00, 'h00FF0000, 0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            checkOutput($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rspv));
            checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            checkOutput($sformatf("v%0d_alu_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].e_ctrl));
            checkOutput($sformatf("v%0d_alu_a", i), alu_a, vecs[i].e_a);
            checkOutput($sformatf("v%0d_alu_b", i), alu_b, vecs[i].e_b);
            checkOutput($sformatf("v%0d_rsp_result", i), rsp_result, vecs[i].e_res);
            checkOutput($sformatf("v%0d_rsp_zero", i), 32'(rsp_zero), 32'(vecs[i].e_zero));
        end

        // Both requesters valid continuously: grants must alternate starting from req0.
        step();
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_alu_ctrl = {4'b0110, 4'b0010};
        req_a = {32'd10, 32'd1};
        req_b = {32'd4, 32'd2};
        #1;
        for (int op = 0; op < 6; op++) begin
            int  exp_idx;
            bit  got;
            exp_idx = op % 2;
            got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                if (c > 0) step();
                checkOutput("ready_two_hot", 32'($countones(req_ready) > 1), 0);
                if (req_ready != 0) got = 1;
            end
            if (!got) checkOutput("grant_timeout", 1, 0);
            checkOutput($sformatf("op%0d_grant", op), 32'(req_ready), 32'(2'b01 << exp_idx));
            got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                step();
                if (rsp_valid != 0) got = 1;
            end
            if (!got) checkOutput("rsp_timeout", 1, 0);
            checkOutput($sformatf("op%0d_rsp_valid", op), 32'(rsp_valid), 32'(2'b01 << exp_idx));
            checkOutput($sformatf("op%0d_rsp_result", op), rsp_result, (exp_idx == 1) ? 32'd6 : 32'd3);
            step();
        end
        req_valid = 2'b00;

        // Stalled response from req0 while req1 waits; ptr is 0 here.
        req_valid = 2'b01; rsp_ready = 2'b00;
        req_alu_ctrl = {4'b0001, 4'b0010};
        req_a = {32'd3, 32'd20};
        req_b = {32'd4, 32'd22};
        #1;
        checkOutput("stall_accept", 32'(req_ready), 32'b01);
        step();
        step();
        checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'b01);
        checkOutput("stall_rsp_result", rsp_result, 32'd42);
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("stall%0d_rsp_valid", i), 32'(rsp_valid), 32'b01);
            checkOutput($sformatf("stall%0d_rsp_result", i), rsp_result, 32'd42);
            checkOutput($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'b00);
        end
        rsp_ready = 2'b01;
        #1;
        checkOutput("release_same_cycle_ready", 32'(req_ready), 32'b00);
        step();
        checkOutput("release_next_ready", 32'(req_ready), 32'b10);
        checkOutput("release_busy", 32'(busy), 0);
        rsp_ready = 2'b11;
        step();
        req_valid = 2'b00;
        step();
        checkOutput("req1_or_valid", 32'(rsp_valid), 32'b10);
        checkOutput("req1_or_result", rsp_result, 32'd7);
        step();

        // Move ptr to 1, park a req1 response, then reset and check ptr returned to 0.
        req_valid = 2'b01;
        req_alu_ctrl = {4'b0010, 4'b0010};
        req_a = {32'd4, 32'd1};
        req_b = {32'd4, 32'd1};
        step();
        req_valid = 2'b00;
        step();
        checkOutput("pre_reset_result", rsp_result, 32'd2);
        step();
        req_valid = 2'b10; rsp_ready = 2'b00;
        #1;
        checkOutput("pre_reset_grant", 32'(req_ready), 32'b10);
        step();
        req_valid = 2'b00;
        step();
        checkOutput("pending_rsp_valid", 32'(rsp_valid), 32'b10);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_rsp_result", rsp_result, 0);
        checkOutput("reset_alu_a", alu_a, 0);
        step();
        rst_n = 1'b1;
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_a = {32'd9, 32'd4};
        req_b = {32'd9, 32'd4};
        #1;
        checkOutput("post_reset_grant", 32'(req_ready), 32'b01);
        step();
        req_valid = 2'b10;
        checkOutput("post_reset_busy", 32'(busy), 1);
        checkOutput("post_reset_alu_a", alu_a, 32'd4);
        step();
        checkOutput("post_reset_rsp_valid", 32'(rsp_valid), 32'b01);
        checkOutput("post_reset_result", rsp_result, 32'd8);
        req_valid = 2'b00;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
